// File: rtl/search_scan_engine_if.sv
// Text-memory read port and highlight-row write port of the search scan engine.
// master = engine side, slave = memory / highlight store side.
interface search_scan_engine_if #(
  parameter int COLS   = 80,
  parameter int ROWS   = 59,
  parameter int CHAR_W = 7,
  parameter int ADDR_W = 13
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [CHAR_W-1:0] rd_data;
  logic              hl_we;
  logic [ROW_W-1:0]  hl_row;
  logic [COLS-1:0]   hl_data;

  modport master (output rd_addr, rd_en, hl_we, hl_row, hl_data, input rd_data);
  modport slave  (input rd_addr, rd_en, hl_we, hl_row, hl_data, output rd_data);
endinterface

// File: rtl/search_scan_engine.sv
// Row-by-row substring search: loads each text row into a line buffer, slides the
// query across every offset and writes a per-row highlight mask.
module search_scan_engine #(
  parameter int COLS   = 80,
  parameter int ROWS   = 59,
  parameter int CHAR_W = 7,
  parameter int MAX_Q  = 40,
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         q_clear,
  input  logic                         q_backspace,
  input  logic                         q_valid,
  input  logic [CHAR_W-1:0]            q_char,
  input  logic                         start,
  input  logic                         case_insens,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_Q+1)-1:0]   q_len,
  output logic [CNT_W-1:0]             match_count,
  search_scan_engine_if.master         bus
);
  localparam int QL_W  = $clog2(MAX_Q + 1);
  localparam int QI_W  = (MAX_Q > 1) ? $clog2(MAX_Q) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = $clog2(COLS + 1);
  localparam int LI_W  = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, WRITE, DONE} state_t;

  state_t             state;
  logic               ci;
  logic [ROW_W-1:0]   row;
  logic [ADDR_W-1:0]  base;
  logic [COL_W-1:0]   col;
  logic [COLS-1:0]    mask;
  logic [CHAR_W-1:0]  line  [COLS];
  logic [CHAR_W-1:0]  query [MAX_Q];
  logic               q_app;
  logic               hit;
  logic [COLS-1:0]    win;

  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c, input logic en);
    if (en && 32'(c) >= 65 && 32'(c) <= 90) return c + CHAR_W'(32);
    return c;
  endfunction

  assign q_app = !busy && !q_clear && !q_backspace && q_valid && (32'(q_len) < MAX_Q);

  // col doubles as the load counter in LOAD and as the match offset in SCAN
  always_comb begin
    hit = (q_len != '0) && (32'(col) + 32'(q_len) <= COLS);
    for (int unsigned i = 0; i < MAX_Q; i++) begin
      if (i < 32'(q_len) && 32'(col) + i < COLS) begin
        if (fold(line[32'(col) + i], ci) != fold(query[i], ci)) hit = 1'b0;
      end
    end
    win = '0;
    for (int unsigned j = 0; j < COLS; j++) begin
      win[j] = hit && (j >= 32'(col)) && (j < 32'(col) + 32'(q_len));
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && col != '0) line[LI_W'(col - COL_W'(1))] <= bus.rd_data;
    if (q_app) query[QI_W'(q_len)] <= q_char;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      q_len       <= '0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ci          <= 1'b0;
      row         <= '0;
      base        <= '0;
      col         <= '0;
      mask        <= '0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.hl_we   <= 1'b0;
      bus.hl_row  <= '0;
      bus.hl_data <= '0;
    end else begin
      if (!busy) begin
        if (q_clear) q_len <= '0;
        else if (q_backspace) begin
          if (q_len != '0) q_len <= q_len - QL_W'(1);
        end else if (q_app) q_len <= q_len + QL_W'(1);
      end

      done      <= 1'b0;
      bus.hl_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ci          <= case_insens;
          match_count <= '0;
          row         <= '0;
          base        <= '0;
          col         <= '0;
          mask        <= '0;
          busy        <= 1'b1;
          bus.rd_en   <= 1'b1;
          bus.rd_addr <= '0;
          state       <= LOAD;
        end
        LOAD: begin
          // reads run one cycle ahead of capture, so LOAD spans COLS+1 cycles
          if (32'(col) + 1 < COLS) bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
          else bus.rd_en <= 1'b0;
          mask <= '0;
          if (32'(col) == COLS) begin
            col   <= '0;
            state <= SCAN;
          end else col <= col + COL_W'(1);
        end
        SCAN: begin
          if (hit && match_count != '1) match_count <= match_count + CNT_W'(1);
          if (32'(col) == COLS - 1) begin
            bus.hl_we   <= 1'b1;
            bus.hl_row  <= row;
            bus.hl_data <= mask | win;
            state       <= WRITE;
          end else begin
            mask <= mask | win;
            col  <= col + COL_W'(1);
          end
        end
        WRITE: begin
          col <= '0;
          if (32'(row) == ROWS - 1) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            row         <= row + ROW_W'(1);
            base        <= base + ADDR_W'(COLS);
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= base + ADDR_W'(COLS);
            state       <= LOAD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_search_scan_engine.sv
// Self-checking bench for search_scan_engine: directed vector table, hand-written
// edit/reset sequences and random passes against a behavioural search model.
module tb_search_scan_engine;
  localparam int COLS = 8, ROWS = 2, CHAR_W = 7, MAX_Q = 4, ADDR_W = 13;

  logic clk = 1'b0, resetn = 1'b1;
  logic q_clear = 1'b0, q_backspace = 1'b0, q_valid = 1'b0, start = 1'b0, case_insens = 1'b0;
  logic [6:0] q_char = '0;
  logic busy, done, busy2, done2;
  logic [2:0] q_len, q_len2;
  logic [3:0] match_count;
  logic [1:0] match_count2;
  logic [6:0] mem [0:15];
  logic [7:0] hl_cap [0:1];
  int hl_cnt = 0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  search_scan_engine_if #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .ADDR_W(ADDR_W)) bus1 (), bus2 ();

  search_scan_engine #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .MAX_Q(MAX_Q), .ADDR_W(ADDR_W), .CNT_W(4)) dut1 (
    .clk(clk), .resetn(resetn), .q_clear(q_clear), .q_backspace(q_backspace), .q_valid(q_valid),
    .q_char(q_char), .start(start), .case_insens(case_insens), .busy(busy), .done(done),
    .q_len(q_len), .match_count(match_count), .bus(bus1.master));

  search_scan_engine #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .MAX_Q(MAX_Q), .ADDR_W(ADDR_W), .CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .q_clear(q_clear), .q_backspace(q_backspace), .q_valid(q_valid),
    .q_char(q_char), .start(start), .case_insens(case_insens), .busy(busy2), .done(done2),
    .q_len(q_len2), .match_count(match_count2), .bus(bus2.master));

  always @(posedge clk) if (bus1.rd_en) bus1.rd_data <= mem[bus1.rd_addr[3:0]];
  always @(posedge clk) if (bus2.rd_en) bus2.rd_data <= mem[bus2.rd_addr[3:0]];

  always @(negedge clk) if (bus1.hl_we === 1'b1) begin
    hl_cap[bus1.hl_row] <= bus1.hl_data;
    hl_cnt <= hl_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_char(input logic [6:0] c);
    q_char = c; q_valid = 1'b1; @(negedge clk); q_valid = 1'b0;
  endtask

  task automatic clear_query();
    q_clear = 1'b1; @(negedge clk); q_clear = 1'b0;
  endtask

  // query strings are 4 characters, first character in the MSB byte, n of them used
  task automatic set_query(input logic [31:0] s, input int n);
    clear_query();
    for (int i = 0; i < n; i++) push_char(s[24-8*i +: 7]);
  endtask

  task automatic load_row(input int r, input logic [63:0] s);
    for (int i = 0; i < 8; i++) mem[r*8+i] = s[56-8*i +: 7];
  endtask

  task automatic run_pass(input logic ci, output int cyc, output int nwr);
    int h0;
    h0 = hl_cnt;
    case_insens = ci; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    check("busy during pass", busy, 1'b1);
    while (done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    check("done seen", done, 1'b1);
    check("dut2 done aligned", done2, 1'b1);
    @(negedge clk);
    check("done single cycle, idle after", {busy, done}, 2'b00);
    nwr = hl_cnt - h0;
  endtask

  function automatic logic [6:0] lower(input logic [6:0] c, input logic en);
    if (en && c >= 7'h41 && c <= 7'h5A) return c ^ 7'h20;
    return c;
  endfunction

  typedef struct packed {
    logic [63:0] r0;
    logic [63:0] r1;
    logic [31:0] q;
    logic [2:0]  ql;
    logic        ci;
    logic [7:0]  m0;
    logic [7:0]  m1;
    logic [4:0]  c4;
    logic [1:0]  c2;
  } vec_t;

  localparam logic [6:0] ALPH [4] = '{7'h61, 7'h62, 7'h41, 7'h42};

  vec_t vt [8];
  int cyc, nwr, h0, cnt, ql;
  int rpts [2];
  logic ok, ci;
  logic [6:0] rc [2][8];
  logic [6:0] qc [4];
  logic [7:0] em [2];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{"abcabcab", "xxxxxxxx", "ab__", 3'd2, 1'b0, 8'hDB, 8'h00, 5'd3, 2'd3};
    vt[1] = '{"aaaaaaaa", "xxxxxxxx", "aaa_", 3'd3, 1'b0, 8'hFF, 8'h00, 5'd6, 2'd3};
    vt[2] = '{"ABabAbzz", "xxxxxxxx", "ab__", 3'd2, 1'b0, 8'h0C, 8'h00, 5'd1, 2'd1};
    vt[3] = '{"ABabAbzz", "xxxxxxxx", "ab__", 3'd2, 1'b1, 8'h3F, 8'h00, 5'd3, 2'd3};
    vt[4] = '{"abababab", "abababab", "ab__", 3'd2, 1'b0, 8'hFF, 8'hFF, 5'd8, 2'd3};
    vt[5] = '{"abcdxxxx", "xxxxxxxx", "abcd", 3'd4, 1'b0, 8'h0F, 8'h00, 5'd1, 2'd1};
    vt[6] = '{"xxxxxxxa", "bxxxxxxx", "ab__", 3'd2, 1'b0, 8'h00, 8'h00, 5'd0, 2'd0};
    vt[7] = '{"xxxxxxab", "abxxxxxx", "ab__", 3'd2, 1'b0, 8'hC0, 8'h03, 5'd2, 2'd2};
    rpts[0] = 10; rpts[1] = 18;
    for (int i = 0; i < 16; i++) mem[i] = 7'h78;

    // asynchronous reset state
    #1 resetn = 1'b0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset q_len", q_len, 3'd0);
    check("reset match_count", match_count, 4'd0);
    check("reset rd_en/hl_we", {bus1.rd_en, bus1.hl_we}, 2'b00);
    check("reset rd_addr", bus1.rd_addr, 13'd0);
    check("reset hl_row/hl_data", {bus1.hl_row, bus1.hl_data}, 9'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // directed vector table
    for (int v = 0; v < 8; v++) begin
      load_row(0, vt[v].r0);
      load_row(1, vt[v].r1);
      set_query(vt[v].q, int'(vt[v].ql));
      check($sformatf("v%0d q_len", v), q_len, vt[v].ql);
      run_pass(vt[v].ci, cyc, nwr);
      check($sformatf("v%0d pass cycles", v), cyc, 37);
      check($sformatf("v%0d row writes", v), nwr, 2);
      check($sformatf("v%0d row0 mask", v), hl_cap[0], vt[v].m0);
      check($sformatf("v%0d row1 mask", v), hl_cap[1], vt[v].m1);
      check($sformatf("v%0d match_count", v), match_count, vt[v].c4);
      check($sformatf("v%0d match_count cnt_w2", v), match_count2, vt[v].c2);
    end

    // edit priority and backspace floor
    set_query("ab__", 2);
    q_clear = 1'b1; q_valid = 1'b1; q_char = 7'h61; @(negedge clk);
    q_clear = 1'b0; q_valid = 1'b0;
    check("clear beats append", q_len, 3'd0);
    q_backspace = 1'b1; @(negedge clk); q_backspace = 1'b0;
    check("backspace held at 0", q_len, 3'd0);
    set_query("ab__", 2);
    q_backspace = 1'b1; q_valid = 1'b1; q_char = 7'h7A; @(negedge clk);
    q_backspace = 1'b0; q_valid = 1'b0;
    check("backspace beats append", q_len, 3'd1);
    load_row(0, "abababab");
    load_row(1, "xxxxxxxx");
    run_pass(1'b0, cyc, nwr);
    check("query 'a' row0 mask", hl_cap[0], 8'h55);
    check("query 'a' match_count", match_count, 4'd4);

    // overflow append then backspace to empty
    clear_query();
    for (int i = 0; i < 5; i++) push_char(7'h61 + 7'(i));
    check("append overflow q_len", q_len, 3'd4);
    load_row(0, "abcdxxxx");
    run_pass(1'b0, cyc, nwr);
    check("dropped char row0 mask", hl_cap[0], 8'h0F);
    check("dropped char match_count", match_count, 4'd1);
    repeat (5) begin q_backspace = 1'b1; @(negedge clk); q_backspace = 1'b0; end
    check("backspace x5 q_len", q_len, 3'd0);
    run_pass(1'b0, cyc, nwr);
    check("empty query cycles", cyc, 37);
    check("empty query writes", nwr, 2);
    check("empty query masks", {hl_cap[0], hl_cap[1]}, 16'h0000);
    check("empty query match_count", match_count, 4'd0);

    // edits and start ignored while busy
    set_query("ab__", 2);
    load_row(0, "abababab");
    case_insens = 1'b0; start = 1'b1; @(negedge clk); start = 1'b0; cyc = 1;
    q_valid = 1'b1; q_char = 7'h61; @(negedge clk); q_valid = 1'b0;
    q_clear = 1'b1; @(negedge clk); q_clear = 1'b0;
    q_backspace = 1'b1; start = 1'b1; @(negedge clk); q_backspace = 1'b0; start = 1'b0;
    cyc = 4;
    check("edits ignored while busy", q_len, 3'd2);
    while (done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    check("mid-pass start ignored, cycles", cyc, 37);
    check("busy-pass match_count", match_count, 4'd4);
    @(negedge clk);

    // reset in the middle of a pass
    for (int k = 0; k < 2; k++) begin
      set_query("ab__", 2);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (rpts[k] - 1) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check($sformatf("rst@%0d busy", rpts[k]), busy, 1'b0);
      check($sformatf("rst@%0d hl_we/rd_en", rpts[k]), {bus1.hl_we, bus1.rd_en}, 2'b00);
      check($sformatf("rst@%0d q_len", rpts[k]), q_len, 3'd0);
      h0 = hl_cnt;
      @(negedge clk); resetn = 1'b1;
      repeat (60) @(negedge clk);
      check($sformatf("rst@%0d no writes after", rpts[k]), hl_cnt - h0, 0);
      check($sformatf("rst@%0d stays idle", rpts[k]), {busy, done}, 2'b00);
    end

    // random passes against the behavioural model
    for (int it = 0; it < 25; it++) begin
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 8; i++) begin
          rc[r][i] = ALPH[$urandom_range(0, 3)];
          mem[r*8+i] = rc[r][i];
        end
      ql = $urandom_range(0, 4);
      ci = 1'($urandom_range(0, 1));
      clear_query();
      for (int k = 0; k < ql; k++) begin
        qc[k] = ALPH[$urandom_range(0, 3)];
        push_char(qc[k]);
      end
      cnt = 0;
      for (int r = 0; r < 2; r++) begin
        em[r] = '0;
        for (int off = 0; off + ql <= 8; off++) begin
          ok = (ql > 0);
          for (int k = 0; k < ql; k++)
            if (lower(rc[r][off+k], ci) != lower(qc[k], ci)) ok = 1'b0;
          if (ok) begin
            cnt++;
            for (int k = 0; k < ql; k++) em[r][off+k] = 1'b1;
          end
        end
      end
      run_pass(ci, cyc, nwr);
      check($sformatf("rand%0d cycles", it), cyc, 37);
      check($sformatf("rand%0d row0 mask", it), hl_cap[0], em[0]);
      check($sformatf("rand%0d row1 mask", it), hl_cap[1], em[1]);
      check($sformatf("rand%0d match_count", it), match_count, (cnt > 15) ? 15 : cnt);
      check($sformatf("rand%0d match_count cnt_w2", it), match_count2, (cnt > 3) ? 3 : cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
